// File: rtl/multicycle_control.sv
// Multi-cycle sequencer for the MIPS-subset datapath: walks each instruction
// through IF/ID/EX/MEM/WB and drives enables, mux selects and the ALU op.
module multicycle_control #(
  parameter int unsigned ALUOP_W = 5
) (
  input  logic               clk,
  input  logic               rst,
  input  logic [5:0]         op,
  input  logic               mem_ready,
  input  logic               branch_taken,
  output logic               pc_wr,
  output logic               ir_wr,
  output logic               iord,
  output logic               mem_rd,
  output logic               mem_wr,
  output logic               reg_wr,
  output logic [1:0]         reg_dst,
  output logic [1:0]         mem_to_reg,
  output logic               alu_src_a,
  output logic [1:0]         alu_src_b,
  output logic               ext_op,
  output logic [1:0]         pc_src,
  output logic [ALUOP_W-1:0] alu_op,
  output logic [2:0]         state,
  output logic               instr_done,
  output logic               illegal
);

  typedef enum logic [2:0] {
    S_IF    = 3'd0,
    S_ID    = 3'd1,
    S_EX    = 3'd2,
    S_MEMRD = 3'd3,
    S_MEMWR = 3'd4,
    S_WB    = 3'd5,
    S_BR    = 3'd6,
    S_JMP   = 3'd7
  } state_e;

  localparam logic [ALUOP_W-1:0] ALU_ADD  = ALUOP_W'(5'b00000);
  localparam logic [ALUOP_W-1:0] ALU_SUB  = ALUOP_W'(5'b00001);
  localparam logic [ALUOP_W-1:0] ALU_SLT  = ALUOP_W'(5'b00010);
  localparam logic [ALUOP_W-1:0] ALU_AND  = ALUOP_W'(5'b00011);
  localparam logic [ALUOP_W-1:0] ALU_OR   = ALUOP_W'(5'b00101);
  localparam logic [ALUOP_W-1:0] ALU_XOR  = ALUOP_W'(5'b00110);
  localparam logic [ALUOP_W-1:0] ALU_SLTU = ALUOP_W'(5'b01000);
  localparam logic [ALUOP_W-1:0] ALU_LUI  = ALUOP_W'(5'b01010);
  localparam logic [ALUOP_W-1:0] ALU_FUNC = ALUOP_W'(5'b11111);

  state_e state_q, state_d;

  logic is_rtype, is_alui, is_load, is_store, is_branch, is_jump, is_jal;
  logic is_legal, zero_ext;
  logic [ALUOP_W-1:0] ex_alu_op;

  // Opcode class decode
  always_comb begin
    is_rtype  = (op == 6'b000000);
    is_alui   = (op[5:3] == 3'b001) && (op[2:0] != 3'b000);
    is_load   = (op == 6'b100011) || (op == 6'b100000) || (op == 6'b100100);
    is_store  = (op == 6'b101011) || (op == 6'b101000);
    is_branch = (op == 6'b000001) || (op[5:2] == 4'b0001);
    is_jal    = (op == 6'b000011);
    is_jump   = (op == 6'b000010) || is_jal;
    is_legal  = is_rtype | is_alui | is_load | is_store | is_branch | is_jump;
    zero_ext  = (op == 6'b001100) || (op == 6'b001101) ||
                (op == 6'b001110) || (op == 6'b001111);
  end

  // Execute-stage ALU operation
  always_comb begin
    ex_alu_op = ALU_ADD;
    if (is_rtype) begin
      ex_alu_op = ALU_FUNC;
    end else begin
      case (op)
        6'b001010: ex_alu_op = ALU_SLT;
        6'b001011: ex_alu_op = ALU_SLTU;
        6'b001100: ex_alu_op = ALU_AND;
        6'b001101: ex_alu_op = ALU_OR;
        6'b001110: ex_alu_op = ALU_XOR;
        6'b001111: ex_alu_op = ALU_LUI;
        default:   ex_alu_op = ALU_ADD;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (rst) state_q <= S_IF;
    else     state_q <= state_d;
  end

  // Next state and Moore outputs (IF/MEMWR/BR also qualify on handshakes)
  always_comb begin
    state_d    = state_q;
    pc_wr      = 1'b0;
    ir_wr      = 1'b0;
    iord       = 1'b0;
    mem_rd     = 1'b0;
    mem_wr     = 1'b0;
    reg_wr     = 1'b0;
    reg_dst    = 2'd0;
    mem_to_reg = 2'd0;
    alu_src_a  = 1'b0;
    alu_src_b  = 2'd0;
    ext_op     = ~zero_ext;
    pc_src     = 2'd0;
    alu_op     = ALU_ADD;
    state      = 3'(state_q);
    instr_done = 1'b0;
    illegal    = 1'b0;

    case (state_q)
      S_IF: begin
        mem_rd    = 1'b1;
        alu_src_b = 2'd1;
        if (mem_ready) begin
          ir_wr   = 1'b1;
          pc_wr   = 1'b1;
          state_d = S_ID;
        end
      end
      S_ID: begin
        alu_src_b = 2'd3;
        if (is_jump)        state_d = S_JMP;
        else if (is_branch) state_d = S_BR;
        else if (is_legal)  state_d = S_EX;
        else begin
          illegal    = 1'b1;
          instr_done = 1'b1;
          state_d    = S_IF;
        end
      end
      S_EX: begin
        alu_src_a = 1'b1;
        alu_src_b = is_rtype ? 2'd0 : 2'd2;
        alu_op    = ex_alu_op;
        if (is_load)       state_d = S_MEMRD;
        else if (is_store) state_d = S_MEMWR;
        else               state_d = S_WB;
      end
      S_MEMRD: begin
        mem_rd = 1'b1;
        iord   = 1'b1;
        if (mem_ready) state_d = S_WB;
      end
      S_MEMWR: begin
        mem_wr = 1'b1;
        iord   = 1'b1;
        if (mem_ready) begin
          instr_done = 1'b1;
          state_d    = S_IF;
        end
      end
      S_WB: begin
        reg_wr     = 1'b1;
        instr_done = 1'b1;
        reg_dst    = is_rtype ? 2'd1 : 2'd0;
        mem_to_reg = is_load ? 2'd1 : 2'd0;
        state_d    = S_IF;
      end
      S_BR: begin
        alu_src_a  = 1'b1;
        alu_op     = ALU_SUB;
        pc_src     = 2'd1;
        pc_wr      = branch_taken;
        instr_done = 1'b1;
        state_d    = S_IF;
      end
      S_JMP: begin
        pc_wr      = 1'b1;
        pc_src     = 2'd2;
        instr_done = 1'b1;
        if (is_jal) begin
          reg_wr     = 1'b1;
          reg_dst    = 2'd2;
          mem_to_reg = 2'd2;
        end
        state_d = S_IF;
      end
      default: state_d = S_IF;
    endcase

    // Reset aborts the instruction and silences every output
    if (rst) begin
      state_d    = S_IF;
      pc_wr      = 1'b0;
      ir_wr      = 1'b0;
      iord       = 1'b0;
      mem_rd     = 1'b0;
      mem_wr     = 1'b0;
      reg_wr     = 1'b0;
      reg_dst    = 2'd0;
      mem_to_reg = 2'd0;
      alu_src_a  = 1'b0;
      alu_src_b  = 2'd0;
      ext_op     = 1'b0;
      pc_src     = 2'd0;
      alu_op     = ALU_ADD;
      state      = 3'd0;
      instr_done = 1'b0;
      illegal    = 1'b0;
    end
  end

endmodule

// File: tb/tb_multicycle_control.sv
// Bench for multicycle_control: per-instruction phase sequences drive a
// table model of the outputs; one negedge process compares every cycle.
module tb_multicycle_control;

  typedef struct packed {
    logic       pc_wr;
    logic       ir_wr;
    logic       iord;
    logic       mem_rd;
    logic       mem_wr;
    logic       reg_wr;
    logic [1:0] reg_dst;
    logic [1:0] mem_to_reg;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic       ext_op;
    logic [1:0] pc_src;
    logic [4:0] alu_op;
    logic [2:0] state;
    logic       instr_done;
    logic       illegal;
  } out_t;

  localparam int P_IF = 0, P_ID = 1, P_EX = 2, P_MEMRD = 3,
                 P_MEMWR = 4, P_WB = 5, P_BR = 6, P_JMP = 7;
  localparam int C_R = 0, C_ALUI = 1, C_LD = 2, C_ST = 3,
                 C_BR = 4, C_J = 5, C_ILL = 6;

  logic clk = 1'b0;
  logic rst = 1'b1;
  logic [5:0] op = 6'd0;
  logic mem_ready = 1'b0;
  logic branch_taken = 1'b0;

  logic pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, ext_op, alu_src_a;
  logic instr_done, illegal;
  logic [1:0] reg_dst, mem_to_reg, alu_src_b, pc_src;
  logic [4:0] alu_op;
  logic [2:0] state;

  int n_vec = 0;
  int n_miss = 0;
  int step_idx = -1;
  logic exp_valid = 1'b0;
  out_t exp_o;
  out_t act_o;
  out_t hist [0:1023];

  multicycle_control #(.ALUOP_W(5)) dut (
    .clk(clk), .rst(rst), .op(op), .mem_ready(mem_ready),
    .branch_taken(branch_taken), .pc_wr(pc_wr), .ir_wr(ir_wr), .iord(iord),
    .mem_rd(mem_rd), .mem_wr(mem_wr), .reg_wr(reg_wr), .reg_dst(reg_dst),
    .mem_to_reg(mem_to_reg), .alu_src_a(alu_src_a), .alu_src_b(alu_src_b),
    .ext_op(ext_op), .pc_src(pc_src), .alu_op(alu_op), .state(state),
    .instr_done(instr_done), .illegal(illegal)
  );

  always #5 clk = ~clk;

  function automatic int cls(input logic [5:0] o);
    if (o == 6'b000000) return C_R;
    if (o inside {6'b001001, 6'b001010, 6'b001011, 6'b001100,
                  6'b001101, 6'b001110, 6'b001111}) return C_ALUI;
    if (o inside {6'b100011, 6'b100000, 6'b100100}) return C_LD;
    if (o inside {6'b101011, 6'b101000}) return C_ST;
    if (o inside {6'b000001, 6'b000100, 6'b000101, 6'b000110, 6'b000111}) return C_BR;
    if (o inside {6'b000010, 6'b000011}) return C_J;
    return C_ILL;
  endfunction

  function automatic logic [4:0] ex_op(input logic [5:0] o);
    if (cls(o) == C_R) return 5'b11111;
    case (o)
      6'b001010: return 5'b00010;
      6'b001011: return 5'b01000;
      6'b001100: return 5'b00011;
      6'b001101: return 5'b00101;
      6'b001110: return 5'b00110;
      6'b001111: return 5'b01010;
      default:   return 5'b00000;
    endcase
  endfunction

  // Output table: what each phase must show for this opcode and handshake
  function automatic out_t exp_out(input int ph, input logic [5:0] o,
                                   input logic mr, input logic br, input logic r);
    out_t e = '0;
    int c = cls(o);
    if (r) return e;
    e.ext_op = !(o inside {6'b001100, 6'b001101, 6'b001110, 6'b001111});
    e.state  = 3'(ph);
    case (ph)
      P_IF:    begin e.mem_rd = 1; e.alu_src_b = 1; e.ir_wr = mr; e.pc_wr = mr; end
      P_ID:    begin e.alu_src_b = 3; e.illegal = (c == C_ILL); e.instr_done = (c == C_ILL); end
      P_EX:    begin e.alu_src_a = 1; e.alu_src_b = (c == C_R) ? 2'd0 : 2'd2; e.alu_op = ex_op(o); end
      P_MEMRD: begin e.mem_rd = 1; e.iord = 1; end
      P_MEMWR: begin e.mem_wr = 1; e.iord = 1; e.instr_done = mr; end
      P_WB:    begin
        e.reg_wr = 1; e.instr_done = 1;
        e.reg_dst = (c == C_R) ? 2'd1 : 2'd0;
        e.mem_to_reg = (c == C_LD) ? 2'd1 : 2'd0;
      end
      P_BR:    begin e.alu_src_a = 1; e.alu_op = 5'b00001; e.pc_src = 1; e.pc_wr = br; e.instr_done = 1; end
      default: begin
        e.pc_wr = 1; e.pc_src = 2; e.instr_done = 1;
        if (o == 6'b000011) begin e.reg_wr = 1; e.reg_dst = 2; e.mem_to_reg = 2; end
      end
    endcase
    return e;
  endfunction

  task automatic step(input int ph, input logic [5:0] o, input logic mr,
                      input logic br, input logic r);
    @(posedge clk);
    #1;
    rst = r; op = o; mem_ready = mr; branch_taken = br;
    step_idx = step_idx + 1;
    exp_o = exp_out(ph, o, mr, br, r);
    exp_valid = 1'b1;
  endtask

  // One instruction as a list of phases; abort=1 asserts rst in the first MEMWR stall
  task automatic run_instr(input logic [5:0] o, input int if_stall, input int mem_stall,
                           input logic br, input logic abort, output int start);
    int c = cls(o);
    start = step_idx + 1;
    for (int i = 0; i < if_stall; i++) step(P_IF, o, 1'b0, br, 1'b0);
    step(P_IF, o, 1'b1, br, 1'b0);
    step(P_ID, o, 1'b1, br, 1'b0);
    if (c == C_ILL) return;
    if (c == C_J)  begin step(P_JMP, o, 1'b1, br, 1'b0); return; end
    if (c == C_BR) begin step(P_BR, o, 1'b1, br, 1'b0); return; end
    step(P_EX, o, 1'b1, br, 1'b0);
    if (c == C_LD) begin
      for (int i = 0; i < mem_stall; i++) step(P_MEMRD, o, 1'b0, br, 1'b0);
      step(P_MEMRD, o, 1'b1, br, 1'b0);
      step(P_WB, o, 1'b0, br, 1'b0);
    end else if (c == C_ST) begin
      if (abort) begin
        step(P_MEMWR, o, 1'b0, br, 1'b0);
        step(P_IF, o, 1'b0, br, 1'b1);
        return;
      end
      for (int i = 0; i < mem_stall; i++) step(P_MEMWR, o, 1'b0, br, 1'b0);
      step(P_MEMWR, o, 1'b1, br, 1'b0);
    end else begin
      step(P_WB, o, 1'b1, br, 1'b0);
    end
  endtask

  task automatic settle();
    @(negedge clk);
    #1;
  endtask

  task automatic lchk(input string nm, input int act, input int expv);
    n_vec = n_vec + 1;
    if (act != expv) begin
      n_miss = n_miss + 1;
      $display("FAIL %s act=%0d exp=%0d", nm, act, expv);
    end
  endtask

  // Cycle-by-cycle compare against the model
  always @(negedge clk) begin
    if (exp_valid) begin
      act_o = '{pc_wr, ir_wr, iord, mem_rd, mem_wr, reg_wr, reg_dst, mem_to_reg,
                alu_src_a, alu_src_b, ext_op, pc_src, alu_op, state, instr_done, illegal};
      hist[step_idx] = act_o;
      n_vec = n_vec + 1;
      if (act_o !== exp_o) begin
        n_miss = n_miss + 1;
        $display("FAIL cycle %0d outputs act=%h exp=%h", step_idx, act_o, exp_o);
      end
    end
  end

  initial begin
    int s;
    int rs;
    logic [5:0] ops [16];
    ops = '{6'b001010, 6'b001011, 6'b001100, 6'b001110, 6'b001111, 6'b100000,
            6'b100100, 6'b101000, 6'b000001, 6'b000101, 6'b000110, 6'b000111,
            6'b000010, 6'b010000, 6'b110001, 6'b000000};

    // Reset, then R-type with mem_ready tied high
    rs = 0;
    step(P_IF, 6'b000000, 1'b1, 1'b0, 1'b1);
    step(P_IF, 6'b000000, 1'b1, 1'b0, 1'b1);
    run_instr(6'b000000, 0, 0, 1'b0, 1'b0, s);
    settle();
    lchk("reset_state", 32'(hist[rs].state), 0);
    lchk("reset_pc_wr", 32'(hist[rs+1].pc_wr), 0);
    lchk("post_rst_mem_rd", 32'(hist[s].mem_rd), 1);
    lchk("post_rst_ir_wr", 32'(hist[s].ir_wr), 1);
    lchk("rtype_ex_aluop", 32'(hist[s+2].alu_op), 31);
    lchk("rtype_ex_srcb", 32'(hist[s+2].alu_src_b), 0);
    lchk("rtype_wb_regdst", 32'(hist[s+3].reg_dst), 1);
    lchk("rtype_wb_state", 32'(hist[s+3].state), 5);

    // LW with two MEMRD wait cycles
    run_instr(6'b100011, 0, 2, 1'b0, 1'b0, s);
    settle();
    lchk("lw_state_memrd", 32'(hist[s+4].state), 3);
    lchk("lw_iord_stall", 32'(hist[s+4].iord), 1);
    lchk("lw_wb_state", 32'(hist[s+6].state), 5);
    lchk("lw_wb_memtoreg", 32'(hist[s+6].mem_to_reg), 1);

    run_instr(6'b001101, 0, 0, 1'b0, 1'b0, s);
    settle();
    lchk("ori_aluop", 32'(hist[s+2].alu_op), 5);
    lchk("ori_ext_op", 32'(hist[s+2].ext_op), 0);
    run_instr(6'b001001, 1, 0, 1'b0, 1'b0, s);
    settle();
    lchk("addiu_ext_op", 32'(hist[s+3].ext_op), 1);
    lchk("addiu_if_stall_irwr", 32'(hist[s].ir_wr), 0);

    run_instr(6'b000100, 0, 0, 1'b0, 1'b0, s);
    settle();
    lchk("beq_nt_pc_wr", 32'(hist[s+2].pc_wr), 0);
    run_instr(6'b000100, 0, 0, 1'b1, 1'b0, s);
    settle();
    lchk("beq_t_pc_wr", 32'(hist[s+2].pc_wr), 1);
    lchk("beq_t_pc_src", 32'(hist[s+2].pc_src), 1);

    run_instr(6'b000011, 0, 0, 1'b0, 1'b0, s);
    settle();
    lchk("jal_reg_dst", 32'(hist[s+2].reg_dst), 2);
    lchk("jal_mem_to_reg", 32'(hist[s+2].mem_to_reg), 2);

    run_instr(6'b111111, 0, 0, 1'b0, 1'b0, s);
    settle();
    lchk("illegal_pulse", 32'(hist[s+1].illegal), 1);

    run_instr(6'b101011, 0, 3, 1'b0, 1'b0, s);
    run_instr(6'b101011, 0, 0, 1'b0, 1'b1, s);
    settle();
    lchk("rst_memwr_mem_wr", 32'(hist[s+4].mem_wr), 0);
    lchk("rst_memwr_state", 32'(hist[s+4].state), 0);

    for (int i = 0; i < 16; i++) run_instr(ops[i], i % 2, i % 3, 1'(i % 2), 1'b0, s);

    settle();
    exp_valid = 1'b0;
    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_miss);
    $finish;
  end

endmodule
